// File: rtl/servo_frame_pkg.sv
// Shared types and constants for the framed servo command controller.
// Contents:
//   state_e          - frame parser states
//   RESP_*           - single-byte response codes returned through uart_tx
package servo_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CH  = 3'd1,
        GET_HI  = 3'd2,
        GET_LO  = 3'd3,
        GET_CHK = 3'd4,
        EVAL    = 3'd5
    } state_e;

    localparam logic [7:0] RESP_ACK       = 8'h06;
    localparam logic [7:0] RESP_ACK_CLAMP = 8'h07;
    localparam logic [7:0] RESP_NAK_CHK   = 8'h15;
    localparam logic [7:0] RESP_NAK_CH    = 8'h16;

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo PWM channel: a shadow width written by the command parser and an
// active width that is only refreshed at the period wrap, so a pulse never
// changes length mid-period.
// Ports:
//   clk, reset_uart  - clock, synchronous active-high reset
//   cnt_i            - shared period counter
//   wrap_i           - high on the last count of the period
//   wr_en_i/wr_val_i - shadow width update (in clk cycles)
//   pwm_o            - registered PWM output (lags the counter by one cycle)
module servo_pwm_ch
    import servo_frame_pkg::*;
#(
    parameter int              CNT_W       = 20,
    parameter logic [CNT_W-1:0] DEFAULT_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_uart,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             wrap_i,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_val_i,
    output logic             pwm_o
);

    logic [CNT_W-1:0] shadow_q;
    logic [CNT_W-1:0] active_q;
    logic             pwm_q;

    always_ff @(posedge clk) begin
        if (reset_uart) begin
            shadow_q <= DEFAULT_VAL;
            active_q <= DEFAULT_VAL;
            pwm_q    <= 1'b0;
        end else begin
            if (wr_en_i) begin
                shadow_q <= wr_val_i;
            end
            // Non-blocking: a shadow write on the wrap cycle lands next period.
            if (wrap_i) begin
                active_q <= shadow_q;
            end
            pwm_q <= (cnt_i < active_q);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/uart_servo_frame_ctrl.sv
// Framed servo command controller. Parses SYNC, CH, W_HI, W_LO, CHK frames from
// the uart_rx byte stream, validates and clamps the commanded width, updates
// the per-channel shadow width and returns a one-byte ACK/NAK through uart_tx.
// Ports:
//   clk, reset_uart      - clock, synchronous active-high reset
//   rx_data, rx_valid    - received byte and its one-cycle strobe
//   tx_data, tx_en       - response byte and one-cycle send strobe
//   tx_busy              - uart_tx busy; holds the pending response
//   pin_pwm              - NUM_CH servo PWM outputs
//   frame_ok, frame_err  - one-cycle frame accept / reject-or-timeout pulses
//   resp_drop            - one-cycle pulse when a pending response is replaced
module uart_servo_frame_ctrl
    import servo_frame_pkg::*;
#(
    parameter int         NUM_CH       = 4,
    parameter int         PERIOD_CLKS  = 540000,
    parameter int         UNIT_CLKS    = 27,
    parameter int         MIN_US       = 500,
    parameter int         MAX_US       = 2500,
    parameter int         DEFAULT_US   = 1500,
    parameter int         TIMEOUT_CLKS = 270000,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_uart,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_busy,
    output logic [NUM_CH-1:0] pin_pwm,
    output logic              frame_ok,
    output logic              frame_err,
    output logic              resp_drop
);

    localparam int               CNT_W    = $clog2(PERIOD_CLKS);
    localparam int               TMO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CLKS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0] DEF_VAL  = CNT_W'(DEFAULT_US * UNIT_CLKS);
    localparam logic [15:0]      MIN_W    = 16'(MIN_US);
    localparam logic [15:0]      MAX_W    = 16'(MAX_US);

    // The compare value is truncated to the counter width, so the widest pulse
    // must fit strictly inside the period.
    if ((MAX_US * UNIT_CLKS >= PERIOD_CLKS) || (NUM_CH < 1) || (NUM_CH > 16)) begin : g_param_check
        $error("uart_servo_frame_ctrl: illegal parameterisation");
    end

    // ---------------- period counter ----------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    assign wrap  = (cnt_q == CNT_LAST);
    assign cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset_uart) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ---------------- frame parser FSM ----------------
    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             in_get;
    logic             timeout;

    assign in_get = (state_q == GET_CH) || (state_q == GET_HI) ||
                    (state_q == GET_LO) || (state_q == GET_CHK);

    // Inter-byte gap counter; only meaningful while inside a frame.
    assign tmo_d = (rx_valid || !in_get) ? '0 : tmo_q + TMO_W'(1);

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        unique case (state_q)
            IDLE:    if (rx_valid && rx_data == SYNC_BYTE) state_d = GET_CH;
            GET_CH:  if (rx_valid) state_d = GET_HI;
            GET_HI:  if (rx_valid) state_d = GET_LO;
            GET_LO:  if (rx_valid) state_d = GET_CHK;
            GET_CHK: if (rx_valid) state_d = EVAL;
            EVAL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (in_get && !rx_valid && tmo_q == TMO_LAST) begin
            state_d = IDLE;
            timeout = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_uart) begin
            state_q <= IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Frame bytes are plain data; they are always rewritten before EVAL reads them.
    logic [7:0] ch_q, hi_q, lo_q, chk_q;

    always_ff @(posedge clk) begin
        if (rx_valid) begin
            if (state_q == GET_CH)  ch_q  <= rx_data;
            if (state_q == GET_HI)  hi_q  <= rx_data;
            if (state_q == GET_LO)  lo_q  <= rx_data;
            if (state_q == GET_CHK) chk_q <= rx_data;
        end
    end

    // ---------------- evaluation ----------------
    logic             eval, chk_ok, ch_ok, accept, clamp_hit;
    logic [15:0]      width_us, clamped_us;
    logic [7:0]       resp_code;
    logic [CNT_W-1:0] wr_val;

    always_comb begin
        eval       = (state_q == EVAL);
        width_us   = {hi_q, lo_q};
        chk_ok     = (chk_q == (ch_q ^ hi_q ^ lo_q));
        ch_ok      = ({24'd0, ch_q} < 32'(NUM_CH));
        accept     = eval && chk_ok && ch_ok;
        clamp_hit  = 1'b0;
        clamped_us = width_us;
        if (width_us < MIN_W) begin
            clamped_us = MIN_W;
            clamp_hit  = 1'b1;
        end else if (width_us > MAX_W) begin
            clamped_us = MAX_W;
            clamp_hit  = 1'b1;
        end
        if (!chk_ok) begin
            resp_code = RESP_NAK_CHK;
        end else if (!ch_ok) begin
            resp_code = RESP_NAK_CH;
        end else if (clamp_hit) begin
            resp_code = RESP_ACK_CLAMP;
        end else begin
            resp_code = RESP_ACK;
        end
        // The shadow register in each channel is the registered product.
        wr_val = CNT_W'(32'(clamped_us) * 32'(UNIT_CLKS));
    end

    // ---------------- response buffer and status pulses ----------------
    logic       pend_q;
    logic [7:0] resp_q;
    logic       frame_ok_q, frame_err_q, resp_drop_q;

    assign tx_en   = pend_q && !tx_busy;
    assign tx_data = resp_q;

    always_ff @(posedge clk) begin
        if (reset_uart) begin
            pend_q      <= 1'b0;
            resp_q      <= 8'h00;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            resp_drop_q <= 1'b0;
        end else begin
            frame_ok_q  <= accept;
            frame_err_q <= (eval && !accept) || timeout;
            resp_drop_q <= 1'b0;
            if (tx_en) begin
                pend_q <= 1'b0;
            end
            if (eval) begin
                pend_q      <= 1'b1;
                resp_q      <= resp_code;
                // Being sent this cycle is not a drop; still waiting is.
                resp_drop_q <= pend_q && !tx_en;
            end
        end
    end

    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign resp_drop = resp_drop_q;

    // ---------------- PWM channels ----------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_pwm_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_VAL (DEF_VAL)
        ) u_ch (
            .clk        (clk),
            .reset_uart (reset_uart),
            .cnt_i      (cnt_q),
            .wrap_i     (wrap),
            .wr_en_i    (accept && (ch_q == 8'(i))),
            .wr_val_i   (wr_val),
            .pwm_o      (pin_pwm[i])
        );
    end

endmodule
